// File: rtl/watch_set_ctrl_if.sv
// watch_set_ctrl_if: button inputs and datapath/display outputs of the watch time-setting controller.
// Latency: none, plain wires between the debouncers, the controller and the datapath.
// Backpressure: none; buttons are sampled every cycle and hms pulses are fire-and-forget.
// Signals: btn_mode (mode-advance pulse), btn_up (increment button level),
//          hms[2:0] (increment pulses: bit0 sec, bit1 min, bit2 hour),
//          mode[1:0] (0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC), setting, blink.
// master: the button/observer side. slave: the controller itself.
interface watch_set_ctrl_if;
   logic       btn_mode;
   logic       btn_up;
   logic [2:0] hms;
   logic [1:0] mode;
   logic       setting;
   logic       blink;

   modport master (
      output btn_mode,
      output btn_up,
      input  hms,
      input  mode,
      input  setting,
      input  blink
   );

   modport slave (
      input  btn_mode,
      input  btn_up,
      output hms,
      output mode,
      output setting,
      output blink
   );
endinterface

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: run/set mode sequencer issuing field-increment pulses, auto-repeat and blink flag.
// Latency: one cycle from a sampled button event to every (registered) output.
// Backpressure: none; the datapath must accept a one-cycle hms pulse whenever it is issued.
// Ports: clk (system clock), reset (async, active-low), bus (watch_set_ctrl_if.slave:
//        btn_mode, btn_up in; hms, mode, setting, blink out).
// Optional build macro: WATCH_SET_CTRL_TIMEOUT_EN adds an idle counter that returns a
// SET state to RUN after TIMEOUT_CNT quiet cycles; without it TIMEOUT_CNT is unused.
module watch_set_ctrl #(
   parameter int HOLD_CNT    = 50_000_000,
   parameter int REPEAT_CNT  = 20_000_000,
   parameter int BLINK_CNT   = 25_000_000,
   parameter int TIMEOUT_CNT = 1_000_000_000
) (
   input  logic             clk,
   input  logic             reset,
   watch_set_ctrl_if.slave  bus
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_SET_HOUR = 2'd1;
   localparam logic [1:0] ST_SET_MIN  = 2'd2;
   localparam logic [1:0] ST_SET_SEC  = 2'd3;

   localparam int HOLD_W  = (HOLD_CNT   > 1) ? $clog2(HOLD_CNT)   : 1;
   localparam int REP_W   = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
   localparam int BLINK_W = (BLINK_CNT  > 1) ? $clog2(BLINK_CNT)  : 1;

   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CNT - 1);
   localparam logic [REP_W-1:0]   REP_LAST   = REP_W'(REPEAT_CNT - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CNT - 1);

   logic [1:0]         mode_q,      mode_d;
   logic               setting_q,   setting_d;
   logic [2:0]         hms_q,       hms_d;
   logic               blink_q,     blink_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               up_prev_q,   up_prev_d;
   // held: the current press started in this field and may still auto-repeat.
   logic               held_q,      held_d;
   // repeating: the initial hold delay has elapsed, now pacing by REPEAT_CNT.
   logic               repeating_q, repeating_d;
   logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
   logic [REP_W-1:0]   rep_cnt_q,   rep_cnt_d;

   logic               up_rise;
   logic               fire;
   logic [2:0]         field_bit;
   logic [1:0]         mode_next;

`ifdef WATCH_SET_CTRL_TIMEOUT_EN
   localparam int IDLE_W = (TIMEOUT_CNT > 1) ? $clog2(TIMEOUT_CNT) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CNT - 1);

   logic [IDLE_W-1:0]  idle_cnt_q,  idle_cnt_d;
   logic               time_out;

   // Idle time only accumulates in a SET state with both buttons quiet.
   always_comb begin
      idle_cnt_d = '0;
      time_out   = 1'b0;
      if (mode_q != ST_RUN && !bus.btn_mode && !bus.btn_up) begin
         if (idle_cnt_q == IDLE_LAST) begin
            time_out = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   logic time_out;
   logic timeout_unused;
   assign time_out       = 1'b0;
   assign timeout_unused = (TIMEOUT_CNT != 0);
`endif

   always_comb begin
      case (mode_q)
         ST_SET_HOUR: begin field_bit = 3'b100; mode_next = ST_SET_MIN; end
         ST_SET_MIN:  begin field_bit = 3'b010; mode_next = ST_SET_SEC; end
         ST_SET_SEC:  begin field_bit = 3'b001; mode_next = ST_RUN;     end
         default:     begin field_bit = 3'b000; mode_next = ST_SET_HOUR; end
      endcase
   end

   always_comb begin
      mode_d      = mode_q;
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      held_d      = held_q;
      repeating_d = repeating_q;
      hold_cnt_d  = hold_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      up_prev_d   = bus.btn_up;
      up_rise     = bus.btn_up & ~up_prev_q;
      fire        = 1'b0;

      if (mode_q == ST_RUN || bus.btn_mode || time_out) begin
         // RUN, a mode change or a timeout: any press in progress is abandoned, so a
         // still-held button must be released and pressed again to adjust a new field.
         held_d      = 1'b0;
         repeating_d = 1'b0;
         hold_cnt_d  = '0;
         rep_cnt_d   = '0;
         blink_cnt_d = '0;
         if (bus.btn_mode) begin
            mode_d  = mode_next;
            blink_d = (mode_next != ST_RUN);
         end else if (time_out) begin
            mode_d  = ST_RUN;
            blink_d = 1'b0;
         end else begin
            blink_d = 1'b0;
         end
      end else begin
         if (!bus.btn_up) begin
            held_d      = 1'b0;
            repeating_d = 1'b0;
            hold_cnt_d  = '0;
            rep_cnt_d   = '0;
         end else if (up_rise) begin
            fire        = 1'b1;
            held_d      = 1'b1;
            repeating_d = 1'b0;
            hold_cnt_d  = '0;
            rep_cnt_d   = '0;
         end else if (held_q) begin
            if (!repeating_q) begin
               if (hold_cnt_q == HOLD_LAST) begin
                  fire        = 1'b1;
                  repeating_d = 1'b1;
                  rep_cnt_d   = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end else begin
               if (rep_cnt_q == REP_LAST) begin
                  fire      = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
            end
         end

         // An increment keeps the field visible by restarting the blink phase.
         if (fire) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
         end else if (blink_cnt_q == BLINK_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end

      hms_d     = fire ? field_bit : 3'b000;
      setting_d = (mode_d != ST_RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q      <= ST_RUN;
         setting_q   <= 1'b0;
         hms_q       <= 3'b000;
         blink_q     <= 1'b0;
         blink_cnt_q <= '0;
         up_prev_q   <= 1'b0;
         held_q      <= 1'b0;
         repeating_q <= 1'b0;
         hold_cnt_q  <= '0;
         rep_cnt_q   <= '0;
      end else begin
         mode_q      <= mode_d;
         setting_q   <= setting_d;
         hms_q       <= hms_d;
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
         up_prev_q   <= up_prev_d;
         held_q      <= held_d;
         repeating_q <= repeating_d;
         hold_cnt_q  <= hold_cnt_d;
         rep_cnt_q   <= rep_cnt_d;
      end
   end

   assign bus.hms     = hms_q;
   assign bus.mode    = mode_q;
   assign bus.setting = setting_q;
   assign bus.blink   = blink_q;

endmodule
